// File: rtl/cpu.sv
// Single-cycle RV32 subset core: ROM fetch, decode, ALU, data RAM and
// register file all settle within one clock period. The core has only clk and
// rst as ports; its activity is observed through the internal nets.

module cpu_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,     // synchronous, active-low
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] regs [0:31];

    // Clear every register on reset, otherwise commit one write per cycle (x0 is never written)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // x0 is hard-wired to zero on both read ports
    assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0000_0000 : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0000_0000 : regs[raddr2_i];
endmodule

module cpu (
    input logic clk,
    input logic rst            // synchronous, active-low
);
    // Opcodes
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Instruction encoders used to build the program ROM readably
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        enc_r = {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm,
                                          input logic [6:0] opc);
        enc_i = {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        enc_s = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction

    // Branch offset is given in half-words (byte offset / 2), since bit 0 is always zero
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] half_off);
        enc_b = {half_off[11], half_off[9:4], rs2, rs1, f3, half_off[3:0], half_off[10], OP_BRANCH};
    endfunction

    // Program ROM contents; every word not listed is 0, which decodes as a NOP
    function automatic logic [31:0] rom_word(input logic [7:0] idx);
        case (idx)
            8'd0:    rom_word = enc_i(3'b000, 5'd1, 5'd0, 12'd5, OP_IMM);          // ADDI x1,x0,5
            8'd1:    rom_word = enc_i(3'b000, 5'd2, 5'd0, 12'd2, OP_IMM);          // ADDI x2,x0,2
            8'd2:    rom_word = enc_r(7'h00, 3'b000, 5'd3,  5'd1, 5'd2);           // ADD  x3
            8'd3:    rom_word = enc_r(7'h20, 3'b000, 5'd4,  5'd2, 5'd1);           // SUB  x4,x2,x1
            8'd4:    rom_word = enc_r(7'h00, 3'b110, 5'd5,  5'd1, 5'd2);           // OR   x5
            8'd5:    rom_word = enc_r(7'h00, 3'b111, 5'd6,  5'd1, 5'd2);           // AND  x6
            8'd6:    rom_word = enc_r(7'h00, 3'b100, 5'd7,  5'd1, 5'd2);           // XOR  x7
            8'd7:    rom_word = enc_r(7'h00, 3'b001, 5'd8,  5'd1, 5'd2);           // SLL  x8
            8'd8:    rom_word = enc_r(7'h00, 3'b101, 5'd9,  5'd1, 5'd2);           // SRL  x9
            8'd9:    rom_word = enc_r(7'h20, 3'b101, 5'd10, 5'd1, 5'd2);           // SRA  x10
            8'd10:   rom_word = enc_r(7'h00, 3'b010, 5'd11, 5'd1, 5'd2);           // SLT  x11
            8'd11:   rom_word = enc_r(7'h00, 3'b011, 5'd12, 5'd1, 5'd2);           // SLTU x12
            8'd12:   rom_word = enc_s(5'd3, 5'd0, 12'd0);                          // SW   x3,0(x0)
            8'd13:   rom_word = enc_i(3'b010, 5'd13, 5'd0, 12'd0, OP_LOAD);        // LW   x13,0(x0)
            8'd14:   rom_word = enc_b(3'b000, 5'd1, 5'd1, 12'd4);                  // BEQ  x1,x1,+8
            8'd15:   rom_word = enc_i(3'b000, 5'd14, 5'd0, 12'd1, OP_IMM);         // ADDI x14,x0,1
            8'd16:   rom_word = enc_i(3'b000, 5'd14, 5'd0, 12'd2, OP_IMM);         // ADDI x14,x0,2
            8'd17:   rom_word = enc_b(3'b000, 5'd0, 5'd0, 12'd0);                  // BEQ  x0,x0,0
            default: rom_word = 32'h0000_0000;
        endcase
    endfunction

    // Observable datapath nets
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] inst;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] mem_data;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_data_s;
    logic [31:0] rs2_data_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_s;
    logic [31:0] op_b_s;
    logic        use_imm_s;
    logic        is_load_s;
    logic        is_branch_s;
    logic        mem_write_s;
    logic        taken_s;

    // Data RAM starts out all-zero and is deliberately untouched by reset
    logic [31:0] dmem [0:255] = '{default: 32'h0000_0000};

    assign inst     = rom_word(pc[9:2]);
    assign opcode_s = inst[6:0];
    assign rd       = inst[11:7];
    assign funct3_s = inst[14:12];
    assign rs1_s    = inst[19:15];
    assign rs2_s    = inst[24:20];

    assign imm_i_s = {{20{inst[31]}}, inst[31:20]};
    assign imm_s_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

    cpu_regfile u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst),
        .raddr1_i (rs1_s),
        .raddr2_i (rs2_s),
        .we_i     (reg_write),
        .waddr_i  (rd),
        .wdata_i  (write_data),
        .rdata1_o (rs1_data_s),
        .rdata2_o (rs2_data_s)
    );

    // Decode opcode/funct fields into ALU operation and datapath controls
    always_comb begin
        alu_op      = ALU_ADD;
        reg_write   = 1'b0;
        mem_write_s = 1'b0;
        use_imm_s   = 1'b0;
        is_load_s   = 1'b0;
        is_branch_s = 1'b0;
        imm_s       = imm_i_s;
        case (opcode_s)
            OP_REG, OP_IMM: begin
                reg_write = 1'b1;
                use_imm_s = (opcode_s == OP_IMM);
                case (funct3_s)
                    // funct7 bit 30 selects SUB only for register-register ops
                    3'b000:  alu_op = (inst[30] && (opcode_s == OP_REG)) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_LOAD: begin
                reg_write = 1'b1;
                use_imm_s = 1'b1;
                is_load_s = 1'b1;
            end
            OP_STORE: begin
                use_imm_s   = 1'b1;
                mem_write_s = 1'b1;
                imm_s       = imm_s_s;
            end
            OP_BRANCH: begin
                alu_op      = ALU_SUB;
                is_branch_s = 1'b1;
                imm_s       = imm_b_s;
            end
            default: begin
                alu_op = ALU_ADD;
            end
        endcase
    end

    assign op_b_s = use_imm_s ? imm_s : rs2_data_s;

    // ALU; shifts use only the low five bits of the second operand
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_result = rs1_data_s + op_b_s;
            ALU_SUB:  alu_result = rs1_data_s - op_b_s;
            ALU_SLL:  alu_result = rs1_data_s << op_b_s[4:0];
            ALU_SLT:  alu_result = {31'd0, ($signed(rs1_data_s) < $signed(op_b_s))};
            ALU_SLTU: alu_result = {31'd0, (rs1_data_s < op_b_s)};
            ALU_XOR:  alu_result = rs1_data_s ^ op_b_s;
            ALU_SRL:  alu_result = rs1_data_s >> op_b_s[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(rs1_data_s) >>> op_b_s[4:0]);
            ALU_OR:   alu_result = rs1_data_s | op_b_s;
            ALU_AND:  alu_result = rs1_data_s & op_b_s;
            default:  alu_result = 32'h0000_0000;
        endcase
    end

    // Branch resolution: BEQ on equal, BNE on not-equal, other funct3 never taken
    always_comb begin
        if (is_branch_s) begin
            case (funct3_s)
                3'b000:  taken_s = (alu_result == 32'h0000_0000);
                3'b001:  taken_s = (alu_result != 32'h0000_0000);
                default: taken_s = 1'b0;
            endcase
        end else begin
            taken_s = 1'b0;
        end
    end

    assign mem_data   = dmem[alu_result[9:2]];
    assign write_data = is_load_s ? mem_data : alu_result;
    assign pc_d       = taken_s ? (pc + imm_s) : (pc + 32'd4);

    // Program counter: reset to 0, otherwise advance to sequential or branch target
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= 32'h0000_0000;
        end else begin
            pc <= pc_d;
        end
    end

    // Store port: writes only when SW executes outside reset
    always_ff @(posedge clk) begin
        if (rst && mem_write_s) begin
            dmem[alu_result[9:2]] <= rs2_data_s;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the single-cycle core: reset behaviour, the built-in
// program's register/memory results, branch skip and halt loop, x0 protection
// and a mid-run reset followed by re-execution.

module tb_cpu;
    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    cpu dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] exp_pc(input int k);
        if (k <= 14)      exp_pc = 32'(4 * k);
        else if (k == 15) exp_pc = 32'h40;
        else              exp_pc = 32'h44;
    endfunction

    task automatic check_final_regs(input string pfx);
        check({pfx, " x1"},  dut.u_regfile.regs[1],  32'd5);
        check({pfx, " x2"},  dut.u_regfile.regs[2],  32'd2);
        check({pfx, " x3"},  dut.u_regfile.regs[3],  32'd7);
        check({pfx, " x4"},  dut.u_regfile.regs[4],  32'hFFFF_FFFD);
        check({pfx, " x5"},  dut.u_regfile.regs[5],  32'd7);
        check({pfx, " x6"},  dut.u_regfile.regs[6],  32'd0);
        check({pfx, " x7"},  dut.u_regfile.regs[7],  32'd7);
        check({pfx, " x8"},  dut.u_regfile.regs[8],  32'd20);
        check({pfx, " x9"},  dut.u_regfile.regs[9],  32'd1);
        check({pfx, " x10"}, dut.u_regfile.regs[10], 32'd1);
        check({pfx, " x11"}, dut.u_regfile.regs[11], 32'd0);
        check({pfx, " x12"}, dut.u_regfile.regs[12], 32'd0);
        check({pfx, " x13"}, dut.u_regfile.regs[13], 32'd7);
        check({pfx, " x14"}, dut.u_regfile.regs[14], 32'd2);
        check({pfx, " dmem0"}, dut.dmem[0], 32'd7);
        check({pfx, " pc"}, dut.pc, 32'h44);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;

        // Reset: two edges with rst low
        step();
        step();
        check("reset pc", dut.pc, 32'h0);
        check("reset inst", dut.inst, 32'h0050_0093);
        check("reset decode reg_write", 32'(dut.reg_write), 32'd1);
        for (int r = 0; r < 32; r++) begin
            check($sformatf("reset x%0d", r), dut.u_regfile.regs[r], 32'h0);
        end

        // Release reset and run 20 cycles, observing selected instructions
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("pc after %0d", k), dut.pc, exp_pc(k));
            if (k == 1) begin
                check("x1 after first edge", dut.u_regfile.regs[1], 32'd5);
            end
            if (k == 3) begin
                check("SUB alu_op", 32'(dut.alu_op), 32'd1);
                check("SUB alu_result", dut.alu_result, 32'hFFFF_FFFD);
                check("SUB rd", 32'(dut.rd), 32'd4);
            end
            if (k == 9) begin
                check("SRA alu_op", 32'(dut.alu_op), 32'd7);
                check("SRA alu_result", dut.alu_result, 32'd1);
            end
            if (k == 11) begin
                check("SLTU alu_op", 32'(dut.alu_op), 32'd4);
            end
            if (k == 12) begin
                check("SW reg_write", 32'(dut.reg_write), 32'd0);
                check("SW alu_result", dut.alu_result, 32'd0);
            end
            if (k == 13) begin
                check("LW dmem0", dut.dmem[0], 32'd7);
                check("LW mem_data", dut.mem_data, 32'd7);
                check("LW write_data", dut.write_data, 32'd7);
                check("LW reg_write", 32'(dut.reg_write), 32'd1);
            end
            if (k == 14) begin
                check("BEQ reg_write", 32'(dut.reg_write), 32'd0);
                check("BEQ alu_op", 32'(dut.alu_op), 32'd1);
            end
            if (k == 15) begin
                check("skipped ADDI x14", dut.u_regfile.regs[14], 32'd0);
            end
        end
        check_final_regs("run1");

        // Halt loop keeps pc at 0x44
        for (int k = 0; k < 4; k++) begin
            step();
            check("halt pc", dut.pc, 32'h44);
        end

        // Inject ADDI x0,x0,9 for one edge: decode tries to write x0
        force dut.inst = 32'h0090_0013;
        #1;
        check("inject reg_write", 32'(dut.reg_write), 32'd1);
        check("inject rd", 32'(dut.rd), 32'd0);
        check("inject alu_result", dut.alu_result, 32'd9);
        @(posedge clk);
        #1;
        release dut.inst;
        @(negedge clk);
        check("x0 after inject", dut.u_regfile.regs[0], 32'h0);
        check("pc after inject", dut.pc, 32'h48);
        step();
        check("pc NOP region", dut.pc, 32'h4C);
        check("x14 kept over NOP", dut.u_regfile.regs[14], 32'd2);

        // Mid-run reset for one edge
        rst = 1'b0;
        step();
        check("midreset pc", dut.pc, 32'h0);
        check("midreset x1", dut.u_regfile.regs[1], 32'h0);
        check("midreset x4", dut.u_regfile.regs[4], 32'h0);
        check("midreset x13", dut.u_regfile.regs[13], 32'h0);
        check("midreset x14", dut.u_regfile.regs[14], 32'h0);
        check("midreset dmem0 kept", dut.dmem[0], 32'd7);

        // Re-execute the program to the same final state
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
        end
        check_final_regs("run2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
